instr_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of the control unit. Holds the PC, issues

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_pc_reg.sv | 41 ++++
 rtl/instr_fetch.sv | 158 +++++++++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: holds the fetch address, steps by one word, or loads an aligned redirect target.
module instr_fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC: redirect beats sequential advance; wraps naturally mod 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = word_align(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: one outstanding imem request, registered IF output, redirect with
// squash of the in-flight response.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic         req_valid_q, req_valid_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  pc_s;
  logic         advance_s;
  logic         req_fire_s;

  assign req_fire_s = req_valid_q & imem_req_ready;

  instr_fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance_s),
    .pc_o          (pc_s)
  );

  // Fetch FSM next-state, kill tracking and IF register capture.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    advance_s  = 1'b0;
    if (redirect_valid) begin
      if_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (req_fire_s) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end
        end
        // A response arriving with the redirect is dropped here, so nothing is left to kill.
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_HOLD: begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end
        default: begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire_s) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid && kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (imem_rsp_valid) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_s;
            if_valid_d = 1'b1;
            advance_s  = 1'b1;
            state_d    = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid_d = 1'b0;
            state_d    = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d    = S_REQ;
          kill_d     = 1'b0;
          if_valid_d = 1'b0;
        end
      endcase
    end
    req_valid_d = (state_d == S_REQ);
  end

  // FSM, kill flag, request-valid and IF output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= RESET_PC;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_s;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign opcode         = if_instr_q[6:0];
  assign funct3         = if_instr_q[14:12];
  assign funct7         = if_instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a small 1-cycle-latency imem model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  int n_checks;
  int n_errors;
  bit auto_rsp;

  instr_fetch #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h00A0_0093;
    else return {a[24:0], 7'b0110011};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: imem model answers an accepted request on the following cycle.
  task automatic step();
    logic        fire;
    logic [31:0] a;
    fire = imem_req_valid & imem_req_ready;
    a    = imem_addr;
    @(posedge clk);
    #1;
    if (auto_rsp && fire) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = mem_word(a);
    end else begin
      imem_rsp_valid = 1'b0;
    end
  endtask

  // Full fetch with no stall, starting from REQ with a visible request.
  task automatic fetch_one(input logic [31:0] exp_addr);
    logic [31:0] w;
    w = mem_word(exp_addr);
    check_eq("req_addr", imem_addr, exp_addr);
    check_eq("req_valid", {31'd0, imem_req_valid}, 32'd1);
    step();
    check_eq("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("wait_if_valid", {31'd0, if_valid}, 32'd0);
    step();
    check_eq("hold_if_valid", {31'd0, if_valid}, 32'd1);
    check_eq("hold_if_pc", if_pc, exp_addr);
    check_eq("hold_if_instr", if_instr, w);
    check_eq("hold_opcode", {25'd0, opcode}, {25'd0, w[6:0]});
    step();
    check_eq("consumed_if_valid", {31'd0, if_valid}, 32'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    auto_rsp       = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    stall          = 1'b0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'h0000_0013);
    check_eq("rst_if_pc", if_pc, RST_PC);
    check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("rst_addr", imem_addr, RST_PC);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // First fetch at RESET_PC, then PC wraps to 0.
    fetch_one(RST_PC);

    // Held instruction at 0 with a 5-cycle stall.
    check_eq("wrap_addr", imem_addr, 32'h0000_0000);
    stall = 1'b1;
    step();
    step();
    check_eq("t2_opcode", {25'd0, opcode}, 32'h0000_0013);
    check_eq("t2_funct3", {29'd0, funct3}, 32'd0);
    check_eq("t2_funct7", {25'd0, funct7}, 32'd0);
    check_eq("t2_if_pc", if_pc, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_stall_valid", {31'd0, if_valid}, 32'd1);
      check_eq("t2_stall_instr", if_instr, 32'h00A0_0093);
      check_eq("t2_stall_noreq", {31'd0, imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    step();
    check_eq("t2_release_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0000_0004);
    fetch_one(32'h0000_0008);

    // Redirect while waiting: late response is killed.
    auto_rsp = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    check_eq("t3_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("t3_addr", imem_addr, 32'h0000_0100);
    check_eq("t3_noreq", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    step();
    check_eq("t3_killed_valid", {31'd0, if_valid}, 32'd0);
    check_eq("t3_rereq", {31'd0, imem_req_valid}, 32'd1);
    auto_rsp = 1'b1;
    fetch_one(32'h0000_0100);

    // Redirect coinciding with the response: response dropped, no stale kill.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check_eq("t3b_if_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0000_0200);

    // Redirect with stall in HOLD.
    stall = 1'b1;
    step();
    step();
    check_eq("t4_hold_valid", {31'd0, if_valid}, 32'd1);
    check_eq("t4_hold_pc", if_pc, 32'h0000_0204);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check_eq("t4_drop_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0000_0300);

    // Redirect while the request is not accepted.
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0403;
    step();
    redirect_valid = 1'b0;
    step();
    check_eq("nr_addr", imem_addr, 32'h0000_0400);
    imem_req_ready = 1'b1;
    fetch_one(32'h0000_0400);

    // Asynchronous reset in the middle of WAIT.
    auto_rsp = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("t6_if_pc", if_pc, RST_PC);
    check_eq("t6_if_instr", if_instr, 32'h0000_0013);
    check_eq("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("t6_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    auto_rsp       = 1'b1;
    step();
    check_eq("t6_stray_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(RST_PC);
    check_eq("t6_wrap_addr", imem_addr, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
